// File: rtl/uart_rx.sv
// uart_rx - 8N1 UART receiver (optional parity via UART_RX_PARITY_EN)
//
// Synchronises the asynchronous rx pin and samples each bit at its midpoint.
// Each received byte is presented on a valid/ready handshake. Line errors are
// reported as single-cycle pulses.
//
// Optional feature macro: UART_RX_PARITY_EN adds a parity bit between the data
// and the stop bit. The expected parity is ^data ^ PARITY_ODD.
//
// Ports:
//   clk         system clock, posedge
//   reset       synchronous, active-high
//   rx          asynchronous serial input, idle high
//   rx_data     received byte, valid while rx_valid=1
//   rx_valid    byte available, held until accepted
//   rx_ready    consumer accepts the byte when rx_valid & rx_ready
//   frame_err   1-cycle pulse: stop bit sampled low
//   overrun     1-cycle pulse: new byte dropped because the previous one is unconsumed
//   parity_err  1-cycle pulse: parity mismatch (always 0 without the macro)
//   busy        1 whenever the FSM is not in IDLE
//
// state  | meaning
// IDLE   | line idle, waiting for rx_s low
// START  | waiting for the start-bit midpoint, rejects glitches
// DATA   | sampling 8 data bits, LSB first
// PARITY | sampling the parity bit (macro only)
// STOP   | sampling the stop bit
// BREAK  | stop bit was low, waiting for the line to return high
module uart_rx #(
  parameter int CLKS_PER_BIT = 234,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  output logic       parity_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t          state, state_nxt;
  logic            rx_meta, rx_s;
  logic [CW-1:0]   cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic            cnt_clr, shift_en, stop_ok, stop_bad, deliver, par_ok;

  // The counter restarts at every sample point. The start-bit midpoint is
  // therefore HALF cycles after T0, and each later sample lies one full bit
  // period after the previous one.
  wire tick_half = (cnt == HALF_M1);
  wire tick_full = (cnt == FULL_M1);

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_en, parity_err_q;
  assign par_ok     = (par_bit == (^shift ^ PARITY_ODD));
  assign parity_err = parity_err_q;
`else
  assign par_ok     = 1'b1;
  // PARITY_ODD has no effect in the 8N1 build.
  assign parity_err = 1'b0 & PARITY_ODD;
`endif

  assign deliver = stop_ok & par_ok;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    shift_en  = 1'b0;
    stop_ok   = 1'b0;
    stop_bad  = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_en    = 1'b0;
`endif
    case (state)
      IDLE: begin
        cnt_clr = 1'b1;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        if (tick_half) begin
          cnt_clr   = 1'b1;
          state_nxt = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_clr  = 1'b1;
          shift_en = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          cnt_clr   = 1'b1;
          par_en    = 1'b1;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          cnt_clr = 1'b1;
          if (rx_s) begin
            stop_ok   = 1'b1;
            state_nxt = IDLE;
          end else begin
            stop_bad  = 1'b1;
            state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bit      <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      cnt     <= cnt_clr ? '0 : cnt + 1'b1;

      if (state == START) bit_idx <= 3'd0;
      if (shift_en) begin
        shift   <= {rx_s, shift[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end
`ifdef UART_RX_PARITY_EN
      if (par_en) par_bit <= rx_s;
      parity_err_q <= stop_ok & ~par_ok;
`endif

      frame_err <= stop_bad;
      overrun   <= deliver & rx_valid & ~rx_ready;

      // An unconsumed byte is never overwritten. A byte accepted in the same
      // cycle as a new delivery is simply replaced, so rx_valid stays high.
      if (deliver && !(rx_valid && !rx_ready)) begin
        rx_data  <= shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
module tb_uart_rx;

  localparam int CPB = 16;
`ifdef UART_RX_PARITY_EN
  localparam int LAT    = 155 + CPB;
  localparam int EXP_PE = 1;
`else
  localparam int LAT    = 155;
  localparam int EXP_PE = 0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;
  logic       parity_err;
  logic       busy;

  uart_rx #(.CLKS_PER_BIT(CPB), .PARITY_ODD(1'b0)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .frame_err  (frame_err),
    .overrun    (overrun),
    .parity_err (parity_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt = 0, ov_cnt = 0, pe_cnt = 0, vr_cnt = 0;
  logic valid_prev = 1'b0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard and flag counters, sampled away from the active edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (rx_valid && rx_ready) begin
        if (exp_q.size() == 0) check("unexpected_byte", {24'h0, rx_data}, 32'hFFFF_FFFF);
        else                   check("rx_data", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
      end
      if (frame_err)  fe_cnt++;
      if (overrun)    ov_cnt++;
      if (parity_err) pe_cnt++;
      if (rx_valid && !valid_prev) vr_cnt++;
      valid_prev = rx_valid;
    end else begin
      valid_prev = 1'b0;
    end
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop_b, input logic par);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`else
    if (par !== par) rx = 1'b1;
`endif
    drive_bit(stop_b);
  endtask

  task automatic send_ok(input logic [7:0] d);
    send_frame(d, 1'b1, ^d);
  endtask

  int fe0, ov0, pe0, vr0;
  task automatic snap();
    fe0 = fe_cnt; ov0 = ov_cnt; pe0 = pe_cnt; vr0 = vr_cnt;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; rx = 1'b1; rx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {26'h0, rx_valid, busy, frame_err, overrun, parity_err, 1'b0}, 32'h0);
    check("reset_data", {24'h0, rx_data}, 32'h0);
    reset = 1'b0;
    repeat (5) @(posedge clk);
    #1;

    // 1: single byte, exact delivery latency, one-cycle rx_valid.
    snap();
    exp_q.push_back(8'h62);
    fork
      send_ok(8'h62);
      begin
        repeat (LAT) @(negedge clk);
        check("t1_valid_before", {31'h0, rx_valid}, 32'h0);
        @(negedge clk);
        check("t1_valid_at", {31'h0, rx_valid}, 32'h1);
        check("t1_data_at", {24'h0, rx_data}, 32'h62);
        @(negedge clk);
        check("t1_valid_after", {31'h0, rx_valid}, 32'h0);
      end
    join
    repeat (5) @(posedge clk);
    #1;
    check("t1_flags", fe_cnt + ov_cnt + pe_cnt - fe0 - ov0 - pe0, 32'h0);

    // 2: back-to-back with consumer stalled -> overrun, first byte kept.
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h31);
    send_ok(8'h31);
    send_ok(8'h0D);
    repeat (10) @(posedge clk);
    #1;
    check("t2_overrun", ov_cnt - ov0, 32'd1);
    check("t2_valid_held", {31'h0, rx_valid}, 32'h1);
    check("t2_data_held", {24'h0, rx_data}, 32'h31);
    rx_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t2_valid_cleared", {31'h0, rx_valid}, 32'h0);
    repeat (3) @(posedge clk);
    #1;

    // 3: 4-cycle glitch is rejected at the start-bit midpoint.
    snap();
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (7) @(negedge clk);
    check("t3_busy_start", {31'h0, busy}, 32'h1);
    @(negedge clk);
    check("t3_busy_idle", {31'h0, busy}, 32'h0);
    repeat (20) @(posedge clk);
    #1;
    check("t3_no_valid", vr_cnt - vr0, 32'h0);
    check("t3_no_flags", fe_cnt + ov_cnt + pe_cnt - fe0 - ov0 - pe0, 32'h0);

    // 4: low stop bit, line held low -> frame error, BREAK, then recovery.
    snap();
    send_frame(8'h0A, 1'b0, ^8'h0A);
    repeat (40) @(posedge clk);
    #1;
    check("t4_frame_err", fe_cnt - fe0, 32'd1);
    check("t4_no_valid", vr_cnt - vr0, 32'h0);
    check("t4_in_break", {31'h0, busy}, 32'h1);
    rx = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("t4_break_exit", {31'h0, busy}, 32'h0);
    exp_q.push_back(8'h0A);
    send_ok(8'h0A);
    repeat (5) @(posedge clk);
    #1;
    check("t4_recv_after", vr_cnt - vr0, 32'd1);
    check("t4_frame_err_once", fe_cnt - fe0, 32'd1);

    // 5: reset in the middle of data bit 4 of 0x55.
    snap();
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'((8'h55 >> i) & 8'h01));
    rx = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("t5_reset_outputs", {27'h0, rx_valid, busy, frame_err, overrun, parity_err}, 32'h0);
    check("t5_reset_data", {24'h0, rx_data}, 32'h0);
    reset = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    snap();
    exp_q.push_back(8'h41);
    send_ok(8'h41);
    repeat (5) @(posedge clk);
    #1;
    check("t5_recv_after", vr_cnt - vr0, 32'd1);

`ifdef UART_RX_PARITY_EN
    // 6: even parity, wrong then right parity bit.
    snap();
    send_frame(8'h07, 1'b1, 1'b0);
    repeat (5) @(posedge clk);
    #1;
    check("t6_parity_err", pe_cnt - pe0, 32'd1);
    check("t6_no_valid", vr_cnt - vr0, 32'h0);
    exp_q.push_back(8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("t6_recv_good", vr_cnt - vr0, 32'd1);
`endif

    repeat (10) @(posedge clk);
    #1;
    check("sb_empty", exp_q.size(), 32'h0);
    check("total_overrun", ov_cnt, 32'd1);
    check("total_frame_err", fe_cnt, 32'd1);
    check("total_parity_err", pe_cnt, EXP_PE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
